// File: rtl/tqvp_vga_copper.sv
// Raster-synchronised display-list sequencer ("copper") for the TinyQV VGA peripheral.
// Replays {scanline, register, value} entries each frame as config writes, sharing the port with the CPU.
module tqvp_vga_copper #(
    parameter int ENTRIES = 8,
    parameter int Y_W     = 10,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_idx,
    input  logic [Y_W+10:0]  prog_data,
    input  logic             frame_start,
    input  logic             new_scanline,
    input  logic [Y_W-1:0]   vga_y,
    input  logic             cpu_cfg_we,
    input  logic [1:0]       cpu_cfg_sel,
    input  logic [8:0]       cpu_cfg_data,
    output logic             cfg_we,
    output logic [1:0]       cfg_sel,
    output logic [8:0]       cfg_data,
    output logic             busy,
    output logic             list_done
);

    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_WAIT, ST_ISSUE, ST_DONE} state_t;

    localparam logic [Y_W-1:0]   EOL  = '1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [Y_W-1:0]   cur_line;

    logic [Y_W-1:0]   tbl_y   [ENTRIES];
    logic [1:0]       tbl_sel [ENTRIES];
    logic [8:0]       tbl_val [ENTRIES];

    logic             cfg_we_d, busy_d, list_done_d, copper_emit;
    logic [1:0]       cfg_sel_d;
    logic [8:0]       cfg_data_d;

    // NOTE: only the y field is reset (to the end-of-list marker); payload storage needs no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl_y[i] <= EOL;
        end else if (prog_we) begin
            tbl_y[prog_idx] <= prog_data[Y_W+10:11];
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we) begin
            tbl_sel[prog_idx] <= prog_data[10:9];
            tbl_val[prog_idx] <= prog_data[8:0];
        end
    end

    // frame_start wins over a simultaneous new_scanline.
    always_ff @(posedge clk) begin
        if (!rst_n)            cur_line <= '0;
        else if (frame_start)  cur_line <= '0;
        else if (new_scanline) cur_line <= vga_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cfg_we    <= 1'b0;
            cfg_sel   <= '0;
            cfg_data  <= '0;
            busy      <= 1'b0;
            list_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cfg_we    <= cfg_we_d;
            cfg_sel   <= cfg_sel_d;
            cfg_data  <= cfg_data_d;
            busy      <= busy_d;
            list_done <= list_done_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (frame_start) begin
            state_d = ST_CHECK;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                ST_CHECK: begin
                    if (tbl_y[ptr_q] == EOL)            state_d = ST_DONE;
                    else if (tbl_y[ptr_q] <= cur_line) state_d = ST_ISSUE;
                    else                                state_d = ST_WAIT;
                end
                ST_WAIT:  if (new_scanline) state_d = ST_CHECK;
                ST_ISSUE: begin
                    if (!cpu_cfg_we) begin
                        if (ptr_q == LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CHECK;
                            ptr_d   = ptr_q + 1'b1;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // CPU has fixed priority; a copper write is granted only in an uninterrupted ISSUE cycle.
    always_comb begin
        copper_emit = en && !frame_start && !cpu_cfg_we && (state_q == ST_ISSUE);
        cfg_we_d    = 1'b0;
        cfg_sel_d   = cfg_sel;
        cfg_data_d  = cfg_data;
        if (cpu_cfg_we) begin
            cfg_we_d   = 1'b1;
            cfg_sel_d  = cpu_cfg_sel;
            cfg_data_d = cpu_cfg_data;
        end else if (copper_emit) begin
            cfg_we_d   = (tbl_sel[ptr_q] != 2'd3);
            cfg_sel_d  = tbl_sel[ptr_q];
            cfg_data_d = tbl_val[ptr_q];
        end
        busy_d      = (state_d == ST_CHECK) || (state_d == ST_ISSUE);
        list_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

endmodule
